risc_v_mike_mc_ctrl_fsm: RTL and testbench
==========================================

# risc_v_mike_mc_ctrl_fsm

Multicycle main-control state machine for the RISC-V Mike core. It sequences the shared ALU, unified memory bus, instruction register and register file across fetch, decode, execute, memory and writeback cycles. It drives the PC update, address-source, ALU-source, result-source and write-enable selects of the top-level datapath, and waits on a memory ready handshake. It sits beside `risc_v_mike_ctrl`, which still decodes `alu_ctrl` from `alu_op`/`funct3`/`funct7`.

## Interface
- No parameters.
- `clk`  in  1  core clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  instruction-register bits [6:0].
- `funct3`  in  3  instruction-register bits [14:12].
- `alu_zero`  in  1  ALU result == 0.
- `alu_slt`  in  1  ALU less-than flag; signedness follows `alu_signed`.
- `mem_ready`  in  1  memory bus has completed the current read or write.
- `pc_update`  out  1  PC register enable.
- `i_or_d`  out  1  memory address select: 1 = PC, 0 = `alu_result_ff`.
- `ir_write`  out  1  instruction-register load.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `reg_write`  out  1  register-file write.
- `alu_src_sel_a`  out  2  ALU A source: 0 = rs1_ff, 1 = PC, 2 = old_pc, 3 = zero.
- `alu_src_sel_b`  out  2  ALU B source: 0 = rs2_ff, 1 = 32'h4, 2 = imm_ext.
- `alu_op`  out  2  0 = add, 1 = compare/sub, 2 = funct decode.
- `alu_signed`  out  1  signed compare.
- `result_src`  out  2  result bus: 0 = `alu_result_ff`, 1 = `data_mem_bus_rd_data_ff`, 2 = `alu_result`.
- `illegal_instr`  out  1  sticky trap flag.
- `instr_retired`  out  1  one-cycle pulse on instruction completion.
- `instret`  out  32  retired-instruction counter.
- `state`  out  4  current state, for debug and SVA.

## Operation
- **State encoding:** BOOT 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC_R 7, EXEC_I 8, ALUWB 9, JAL 10, JALR 11, LINK 12, BRANCH 13, UPPER 14, TRAP 15.
- **Defaults:** every output not listed for a state is 0.
- **BOOT:** outputs 0. Goes to FETCH.
- **FETCH:** `i_or_d`=1, `mem_read`=1, a=1, b=1, `alu_op`=0, `result_src`=2. When `mem_ready`=1: `ir_write`=1, `pc_update`=1, go to DECODE. Otherwise hold.
- **DECODE:** a=2, b=2, add (branch/JAL target lands in `alu_result_ff`). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BRANCH
  - 0110111 or 0010111 → UPPER
  - any other → TRAP
- **MEMADR:** a=0, b=2, add. opcode[5]=0 → MEMRD, else → MEMWR.
- **MEMRD:** `i_or_d`=0, `mem_read`=1. Hold until `mem_ready`, then go to MEMWB.
- **MEMWB:** `result_src`=1, `reg_write`=1. Retire, go to FETCH.
- **MEMWR:** `i_or_d`=0, `mem_write`=1. Hold until `mem_ready`, then retire and go to FETCH.
- **EXEC_R:** a=0, b=0, `alu_op`=2. Go to ALUWB.
- **EXEC_I:** a=0, b=2, `alu_op`=2. Go to ALUWB.
- **ALUWB:** `result_src`=0, `reg_write`=1. Retire, go to FETCH.
- **JAL:** a=2, b=1, add, `result_src`=0, `pc_update`=1. Go to ALUWB.
- **JALR:** a=0, b=2, add, `result_src`=2, `pc_update`=1. Go to LINK.
- **LINK:** a=2, b=1, add. Go to ALUWB.
- **BRANCH:** a=0, b=0, `alu_op`=1, `result_src`=0, `alu_signed`=~funct3[1].
  - Taken condition by funct3: 000 `alu_zero`; 001 ~`alu_zero`; 100/110 `alu_slt`; 101/111 ~`alu_slt`; 010/011 never.
  - `pc_update` = taken. Retire, go to FETCH.
- **UPPER:** a = opcode[5] ? 3 : 2, b=2, add. Go to ALUWB.
- **TRAP:** all outputs 0 except `illegal_instr`=1. Stays in TRAP until reset.
- **Handshake:** `mem_read`/`mem_write` stay constant while waiting. `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- **Retire pulse:** `instr_retired` is asserted in the final cycle of each instruction. `instret` increments on that edge and wraps from 0xFFFFFFFF to 0.

## Timing
- State register and `instret` are asynchronously cleared when `rst`=0; state → BOOT, `instret` → 0. While `rst`=0, all outputs are 0.
- Reset deasserted mid-instruction restarts at BOOT. No partial write may follow: writes occur only in write states, which reset exits.
- All control outputs are combinational from state, `opcode`, `funct3`, flags and `mem_ready`. There is no output register.
- Cycles per instruction with `mem_ready` tied to 1: lw 5, sw 4, R-type 4, I-type 4, jal 4, jalr 5, branch 3, lui/auipc 4.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- First FETCH occurs in the cycle after BOOT, i.e. the second cycle after reset release.

## Test plan
- Reset release, `mem_ready`=1, instruction add (0x00208033) → states 0,1,2,7,9,1. `reg_write`=1 only in ALUWB. `instret`=1 after ALUWB.
- lw with `mem_ready` low for 3 cycles in MEMRD → `mem_read`=1 and `i_or_d`=0 stable for 4 cycles. `result_src`=1 and `reg_write`=1 in MEMWB. Total 8 cycles.
- beq with `alu_zero`=1, then with `alu_zero`=0 → `pc_update`=1 with `result_src`=0 in BRANCH, then `pc_update`=0. 3 cycles each.
- bltu: funct3=110 → `alu_signed`=0. `pc_update` follows `alu_slt`.
- jalr → JALR asserts `pc_update` with `result_src`=2. LINK uses a=2, b=1. ALUWB writes. 5 cycles.
- Opcode 0x7F → TRAP, `illegal_instr`=1 sticky and `instret` frozen. Asserting `rst`=0 mid-TRAP clears to BOOT immediately.

Source files
------------

// File: rtl/risc_v_mike_mc_ctrl_fsm_if.sv
// Unified memory bus handshake between the multicycle control FSM and the memory port.
// The FSM is the master: it selects the address source and requests reads/writes.
interface risc_v_mike_mc_ctrl_fsm_if;
  logic i_or_d;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (
    output i_or_d,
    output mem_read,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  i_or_d,
    input  mem_read,
    input  mem_write,
    output mem_ready
  );
endinterface

// File: rtl/risc_v_mike_mc_ctrl_fsm.sv
// Multicycle main-control FSM for the RISC-V Mike core: sequences fetch, decode,
// execute, memory and writeback; outputs are decoded combinationally from state.
module risc_v_mike_mc_ctrl_fsm (
  input  logic                              clk,
  input  logic                              rst,
  risc_v_mike_mc_ctrl_fsm_if.master         mem,
  input  logic [6:0]                        opcode,
  input  logic [2:0]                        funct3,
  input  logic                              alu_zero,
  input  logic                              alu_slt,
  output logic                              pc_update,
  output logic                              ir_write,
  output logic                              reg_write,
  output logic [1:0]                        alu_src_sel_a,
  output logic [1:0]                        alu_src_sel_b,
  output logic [1:0]                        alu_op,
  output logic                              alu_signed,
  output logic [1:0]                        result_src,
  output logic                              illegal_instr,
  output logic                              instr_retired,
  output logic [31:0]                       instret,
  output logic [3:0]                        state
);

  typedef enum logic [3:0] {
    S_BOOT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_ALUWB  = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_LINK   = 4'd12,
    S_BRANCH = 4'd13,
    S_UPPER  = 4'd14,
    S_TRAP   = 4'd15
  } state_t;

  state_t state_q;
  state_t state_next;
  logic   branch_taken;

  assign state = state_q;

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:          branch_taken = alu_zero;
      3'b001:          branch_taken = ~alu_zero;
      3'b100, 3'b110:  branch_taken = alu_slt;
      3'b101, 3'b111:  branch_taken = ~alu_slt;
      default:         branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_BOOT:   state_next = S_FETCH;
      S_FETCH:  if (mem.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: state_next = S_MEMADR;
          7'b0110011:             state_next = S_EXEC_R;
          7'b0010011:             state_next = S_EXEC_I;
          7'b1101111:             state_next = S_JAL;
          7'b1100111:             state_next = S_JALR;
          7'b1100011:             state_next = S_BRANCH;
          7'b0110111, 7'b0010111: state_next = S_UPPER;
          default:                state_next = S_TRAP;
        endcase
      end
      S_MEMADR: state_next = opcode[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem.mem_ready) state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  if (mem.mem_ready) state_next = S_FETCH;
      S_EXEC_R: state_next = S_ALUWB;
      S_EXEC_I: state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_JAL:    state_next = S_ALUWB;
      S_JALR:   state_next = S_LINK;
      S_LINK:   state_next = S_ALUWB;
      S_BRANCH: state_next = S_FETCH;
      S_UPPER:  state_next = S_ALUWB;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_BOOT;
    endcase
  end

  // Anything not driven by a state stays 0, so BOOT (the reset state) keeps the bus quiet.
  always_comb begin
    pc_update     = 1'b0;
    mem.i_or_d    = 1'b0;
    ir_write      = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    reg_write     = 1'b0;
    alu_src_sel_a = 2'd0;
    alu_src_sel_b = 2'd0;
    alu_op        = 2'd0;
    alu_signed    = 1'b0;
    result_src    = 2'd0;
    illegal_instr = 1'b0;
    instr_retired = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.i_or_d    = 1'b1;
        mem.mem_read  = 1'b1;
        alu_src_sel_a = 2'd1;
        alu_src_sel_b = 2'd1;
        result_src    = 2'd2;
        ir_write      = mem.mem_ready;
        pc_update     = mem.mem_ready;
      end
      S_DECODE: begin
        alu_src_sel_a = 2'd2;
        alu_src_sel_b = 2'd2;
      end
      S_MEMADR, S_EXEC_I: begin
        alu_src_sel_b = 2'd2;
        alu_op        = (state_q == S_EXEC_I) ? 2'd2 : 2'd0;
      end
      S_MEMRD: begin
        mem.mem_read  = 1'b1;
      end
      S_MEMWB: begin
        result_src    = 2'd1;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWR: begin
        mem.mem_write = 1'b1;
        instr_retired = mem.mem_ready;
      end
      S_EXEC_R: begin
        alu_op        = 2'd2;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_JAL: begin
        alu_src_sel_a = 2'd2;
        alu_src_sel_b = 2'd1;
        pc_update     = 1'b1;
      end
      S_JALR: begin
        alu_src_sel_b = 2'd2;
        result_src    = 2'd2;
        pc_update     = 1'b1;
      end
      S_LINK: begin
        alu_src_sel_a = 2'd2;
        alu_src_sel_b = 2'd1;
      end
      S_BRANCH: begin
        alu_op        = 2'd1;
        alu_signed    = ~funct3[1];
        pc_update     = branch_taken;
        instr_retired = 1'b1;
      end
      S_UPPER: begin
        alu_src_sel_a = opcode[5] ? 2'd3 : 2'd2;
        alu_src_sel_b = 2'd2;
      end
      S_TRAP: begin
        illegal_instr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
      instret <= 32'd0;
    end else begin
      state_q <= state_next;
      if (instr_retired) instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_risc_v_mike_mc_ctrl_fsm.sv
// Directed testbench for the multicycle control FSM: walks add, lw (with memory stall),
// beq, bltu, jalr, sw and an illegal opcode, checking decoded controls every cycle.
module tb_risc_v_mike_mc_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alu_zero;
  logic        alu_slt;
  logic        pc_update;
  logic        ir_write;
  logic        reg_write;
  logic [1:0]  alu_src_sel_a;
  logic [1:0]  alu_src_sel_b;
  logic [1:0]  alu_op;
  logic        alu_signed;
  logic [1:0]  result_src;
  logic        illegal_instr;
  logic        instr_retired;
  logic [31:0] instret;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;

  risc_v_mike_mc_ctrl_fsm_if bus ();

  risc_v_mike_mc_ctrl_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .mem           (bus.master),
    .opcode        (opcode),
    .funct3        (funct3),
    .alu_zero      (alu_zero),
    .alu_slt       (alu_slt),
    .pc_update     (pc_update),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .alu_src_sel_a (alu_src_sel_a),
    .alu_src_sel_b (alu_src_sel_b),
    .alu_op        (alu_op),
    .alu_signed    (alu_signed),
    .result_src    (result_src),
    .illegal_instr (illegal_instr),
    .instr_retired (instr_retired),
    .instret       (instret),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected vector: state, pc_update, i_or_d, ir_write, mem_read, mem_write, reg_write,
  // a, b, alu_op, alu_signed, result_src, illegal_instr, instr_retired.
  task automatic check_ctrl(input string tag, input logic [3:0] st,
                            input logic pcu, input logic iod, input logic irw,
                            input logic mrd, input logic mwr, input logic rw,
                            input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                            input logic sgn, input logic [1:0] res,
                            input logic ill, input logic ret);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = {11'd0, state, pc_update, bus.i_or_d, ir_write, bus.mem_read, bus.mem_write,
           reg_write, alu_src_sel_a, alu_src_sel_b, alu_op, alu_signed, result_src,
           illegal_instr, instr_retired};
    exp = {11'd0, st, pcu, iod, irw, mrd, mwr, rw, a, b, op, sgn, res, ill, ret};
    check_output(tag, obs, exp);
  endtask

  task automatic apply_stimulus(input logic [6:0] opc, input logic [2:0] f3,
                                input logic ready, input logic zero, input logic slt);
    @(negedge clk);
    opcode        = opc;
    funct3        = f3;
    bus.mem_ready = ready;
    alu_zero      = zero;
    alu_slt       = slt;
    #1;
  endtask

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  initial begin
    rst           = 1'b0;
    opcode        = OP_R;
    funct3        = 3'b000;
    bus.mem_ready = 1'b1;
    alu_zero      = 1'b0;
    alu_slt       = 1'b0;
    $display("[TB] start");
    repeat (2) @(negedge clk);
    #1;
    check_ctrl("reset_outputs", 4'd0, 0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0, 2'd0, 0,0);
    check_output("reset_instret", instret, 32'd0);

    // add x0,x1,x2 with mem_ready tied high
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_ctrl("add_boot",   4'd0, 0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0, 2'd0, 0,0);
    apply_stimulus(OP_R, 3'b000, 1, 0, 0);
    check_ctrl("add_fetch",  4'd1, 1,1,1,1,0,0, 2'd1,2'd1,2'd0, 0, 2'd2, 0,0);
    apply_stimulus(OP_R, 3'b000, 1, 0, 0);
    check_ctrl("add_decode", 4'd2, 0,0,0,0,0,0, 2'd2,2'd2,2'd0, 0, 2'd0, 0,0);
    apply_stimulus(OP_R, 3'b000, 1, 0, 0);
    check_ctrl("add_exec_r", 4'd7, 0,0,0,0,0,0, 2'd0,2'd0,2'd2, 0, 2'd0, 0,0);
    apply_stimulus(OP_R, 3'b000, 1, 0, 0);
    check_ctrl("add_aluwb",  4'd9, 0,0,0,0,0,1, 2'd0,2'd0,2'd0, 0, 2'd0, 0,1);
    check_output("add_instret_before", instret, 32'd0);

    // lw with three stall cycles in MEMRD
    apply_stimulus(OP_LD, 3'b010, 1, 0, 0);
    check_ctrl("lw_fetch",   4'd1, 1,1,1,1,0,0, 2'd1,2'd1,2'd0, 0, 2'd2, 0,0);
    check_output("add_instret_after", instret, 32'd1);
    apply_stimulus(OP_LD, 3'b010, 1, 0, 0);
    check_ctrl("lw_decode",  4'd2, 0,0,0,0,0,0, 2'd2,2'd2,2'd0, 0, 2'd0, 0,0);
    apply_stimulus(OP_LD, 3'b010, 0, 0, 0);
    check_ctrl("lw_memadr",  4'd3, 0,0,0,0,0,0, 2'd0,2'd2,2'd0, 0, 2'd0, 0,0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(OP_LD, 3'b010, 0, 0, 0);
      check_ctrl($sformatf("lw_memrd_stall%0d", i), 4'd4, 0,0,0,1,0,0, 2'd0,2'd0,2'd0, 0, 2'd0, 0,0);
    end
    apply_stimulus(OP_LD, 3'b010, 1, 0, 0);
    check_ctrl("lw_memrd_ready", 4'd4, 0,0,0,1,0,0, 2'd0,2'd0,2'd0, 0, 2'd0, 0,0);
    apply_stimulus(OP_LD, 3'b010, 1, 0, 0);
    check_ctrl("lw_memwb",   4'd5, 0,0,0,0,0,1, 2'd0,2'd0,2'd0, 0, 2'd1, 0,1);

    // beq taken, preceded by one FETCH stall
    apply_stimulus(OP_BR, 3'b000, 0, 1, 0);
    check_ctrl("beq_fetch_stall", 4'd1, 0,1,0,1,0,0, 2'd1,2'd1,2'd0, 0, 2'd2, 0,0);
    check_output("lw_instret", instret, 32'd2);
    apply_stimulus(OP_BR, 3'b000, 1, 1, 0);
    check_ctrl("beq_fetch",  4'd1, 1,1,1,1,0,0, 2'd1,2'd1,2'd0, 0, 2'd2, 0,0);
    apply_stimulus(OP_BR, 3'b000, 1, 1, 0);
    check_ctrl("beq_decode", 4'd2, 0,0,0,0,0,0, 2'd2,2'd2,2'd0, 0, 2'd0, 0,0);
    apply_stimulus(OP_BR, 3'b000, 1, 1, 0);
    check_ctrl("beq_taken",  4'd13, 1,0,0,0,0,0, 2'd0,2'd0,2'd1, 1, 2'd0, 0,1);

    // beq not taken
    apply_stimulus(OP_BR, 3'b000, 1, 0, 0);
    check_ctrl("beq2_fetch", 4'd1, 1,1,1,1,0,0, 2'd1,2'd1,2'd0, 0, 2'd2, 0,0);
    apply_stimulus(OP_BR, 3'b000, 1, 0, 0);
    apply_stimulus(OP_BR, 3'b000, 1, 0, 0);
    check_ctrl("beq_not_taken", 4'd13, 0,0,0,0,0,0, 2'd0,2'd0,2'd1, 1, 2'd0, 0,1);

    // bltu: unsigned compare, pc_update follows alu_slt within the cycle
    apply_stimulus(OP_BR, 3'b110, 1, 0, 1);
    check_output("beq_instret", instret, 32'd4);
    apply_stimulus(OP_BR, 3'b110, 1, 0, 1);
    apply_stimulus(OP_BR, 3'b110, 1, 0, 1);
    check_ctrl("bltu_taken", 4'd13, 1,0,0,0,0,0, 2'd0,2'd0,2'd1, 0, 2'd0, 0,1);
    alu_slt = 1'b0;
    #1;
    check_output("bltu_slt_low_pc_update", {31'd0, pc_update}, 32'd0);

    // jalr
    apply_stimulus(OP_JR, 3'b000, 1, 0, 0);
    check_output("bltu_instret", instret, 32'd5);
    apply_stimulus(OP_JR, 3'b000, 1, 0, 0);
    apply_stimulus(OP_JR, 3'b000, 1, 0, 0);
    check_ctrl("jalr_jalr",  4'd11, 1,0,0,0,0,0, 2'd0,2'd2,2'd0, 0, 2'd2, 0,0);
    apply_stimulus(OP_JR, 3'b000, 1, 0, 0);
    check_ctrl("jalr_link",  4'd12, 0,0,0,0,0,0, 2'd2,2'd1,2'd0, 0, 2'd0, 0,0);
    apply_stimulus(OP_JR, 3'b000, 1, 0, 0);
    check_ctrl("jalr_aluwb", 4'd9, 0,0,0,0,0,1, 2'd0,2'd0,2'd0, 0, 2'd0, 0,1);

    // sw
    apply_stimulus(OP_ST, 3'b010, 1, 0, 0);
    check_output("jalr_instret", instret, 32'd6);
    apply_stimulus(OP_ST, 3'b010, 1, 0, 0);
    apply_stimulus(OP_ST, 3'b010, 1, 0, 0);
    check_ctrl("sw_memadr",  4'd3, 0,0,0,0,0,0, 2'd0,2'd2,2'd0, 0, 2'd0, 0,0);
    apply_stimulus(OP_ST, 3'b010, 1, 0, 0);
    check_ctrl("sw_memwr",   4'd6, 0,0,0,0,1,0, 2'd0,2'd0,2'd0, 0, 2'd0, 0,1);

    // illegal opcode traps and holds until reset
    apply_stimulus(OP_BAD, 3'b000, 1, 0, 0);
    check_output("sw_instret", instret, 32'd7);
    apply_stimulus(OP_BAD, 3'b000, 1, 0, 0);
    apply_stimulus(OP_BAD, 3'b000, 1, 0, 0);
    check_ctrl("trap_enter", 4'd15, 0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0, 2'd0, 1,0);
    apply_stimulus(OP_R, 3'b000, 1, 1, 1);
    check_ctrl("trap_sticky", 4'd15, 0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0, 2'd0, 1,0);
    check_output("trap_instret_frozen", instret, 32'd7);
    #2;
    rst = 1'b0;
    #1;
    check_ctrl("trap_async_reset", 4'd0, 0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0, 2'd0, 0,0);
    check_output("trap_reset_instret", instret, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
